// File: rtl/sort_1.sv
// Three-input descending sorter: a three-stage compare/exchange network
// feeding registered outputs, one new triple accepted every cycle.
module sort_1 #(
  parameter int width = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic [width-1:0] c,
  output logic [width-1:0] no1,
  output logic [width-1:0] no2,
  output logic [width-1:0] no3
);

  logic [width-1:0] s1_x0_s, s1_x1_s;
  logic [width-1:0] s2_x1_s, s2_x2_s;
  logic [width-1:0] s3_x0_s, s3_x1_s;

  // Compare/exchange network; swaps only on strict greater-than so ties stay put.
  always_comb begin
    s1_x0_s = a;
    s1_x1_s = b;
    s2_x1_s = {width{1'b0}};
    s2_x2_s = {width{1'b0}};
    s3_x0_s = {width{1'b0}};
    s3_x1_s = {width{1'b0}};

    if (b > a) begin
      s1_x0_s = b;
      s1_x1_s = a;
    end else begin
      s1_x0_s = a;
      s1_x1_s = b;
    end

    if (c > s1_x1_s) begin
      s2_x1_s = c;
      s2_x2_s = s1_x1_s;
    end else begin
      s2_x1_s = s1_x1_s;
      s2_x2_s = c;
    end

    if (s2_x1_s > s1_x0_s) begin
      s3_x0_s = s2_x1_s;
      s3_x1_s = s1_x0_s;
    end else begin
      s3_x0_s = s1_x0_s;
      s3_x1_s = s2_x1_s;
    end
  end

  // Output registers; reset wins over the triple sampled on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      no1 <= {width{1'b0}};
      no2 <= {width{1'b0}};
      no3 <= {width{1'b0}};
    end else begin
      no1 <= s3_x0_s;
      no2 <= s3_x1_s;
      no3 <= s2_x2_s;
    end
  end

endmodule

// File: tb/tb_sort_1.sv
// Self-checking bench for sort_1: directed vector table, latency sequence,
// and exhaustive 3-bit sweep with a mid-stream reset.
module tb_sort_1;

  logic       clk;
  logic       rst;
  logic [2:0] a, b, c;
  logic [2:0] no1, no2, no3;

  int n_checks = 0;
  int n_fail   = 0;

  sort_1 #(.width(3)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
    .no1(no1), .no2(no2), .no3(no3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0] a, b, c;
    logic       rst;
    logic [2:0] e1, e2, e3;
  } vec_t;

  vec_t vecs[15];

  // Reference: max, min, and median as the sum remainder.
  function automatic logic [8:0] sort_model(input int x, input int y, input int z);
    int mx, mn, md;
    mx = (x >= y) ? ((x >= z) ? x : z) : ((y >= z) ? y : z);
    mn = (x <= y) ? ((x <= z) ? x : z) : ((y <= z) ? y : z);
    md = x + y + z - mx - mn;
    return {mx[2:0], md[2:0], mn[2:0]};
  endfunction

  task automatic check(input string name, input logic [2:0] e1, input logic [2:0] e2,
                       input logic [2:0] e3);
    n_checks++;
    if ({no1, no2, no3} !== {e1, e2, e3}) begin
      n_fail++;
      $display("FAIL %s: got %0d,%0d,%0d expected %0d,%0d,%0d",
               name, no1, no2, no3, e1, e2, e3);
    end
  endtask

  task automatic apply(input logic [2:0] ta, input logic [2:0] tb, input logic [2:0] tc,
                       input logic trst, input logic [2:0] e1, input logic [2:0] e2,
                       input logic [2:0] e3, input string name);
    a   = ta;
    b   = tb;
    c   = tc;
    rst = trst;
    @(posedge clk);
    #1;
    check(name, e1, e2, e3);
  endtask

  initial begin
    rst = 1'b1;
    a = 3'd0; b = 3'd0; c = 3'd0;

    vecs[0]  = '{3'd7, 3'd5, 3'd3, 1'b1, 3'd0, 3'd0, 3'd0};
    vecs[1]  = '{3'd7, 3'd5, 3'd3, 1'b1, 3'd0, 3'd0, 3'd0};
    vecs[2]  = '{3'd7, 3'd5, 3'd3, 1'b0, 3'd7, 3'd5, 3'd3};
    vecs[3]  = '{3'd1, 3'd4, 3'd6, 1'b0, 3'd6, 3'd4, 3'd1};
    vecs[4]  = '{3'd1, 3'd6, 3'd4, 1'b0, 3'd6, 3'd4, 3'd1};
    vecs[5]  = '{3'd4, 3'd1, 3'd6, 1'b0, 3'd6, 3'd4, 3'd1};
    vecs[6]  = '{3'd4, 3'd6, 3'd1, 1'b0, 3'd6, 3'd4, 3'd1};
    vecs[7]  = '{3'd6, 3'd1, 3'd4, 1'b0, 3'd6, 3'd4, 3'd1};
    vecs[8]  = '{3'd6, 3'd4, 3'd1, 1'b0, 3'd6, 3'd4, 3'd1};
    vecs[9]  = '{3'd3, 3'd3, 3'd1, 1'b0, 3'd3, 3'd3, 3'd1};
    vecs[10] = '{3'd2, 3'd5, 3'd5, 1'b0, 3'd5, 3'd5, 3'd2};
    vecs[11] = '{3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0};
    vecs[12] = '{3'd7, 3'd7, 3'd7, 1'b0, 3'd7, 3'd7, 3'd7};
    vecs[13] = '{3'd0, 3'd7, 3'd0, 1'b0, 3'd7, 3'd0, 3'd0};
    vecs[14] = '{3'd7, 3'd0, 3'd7, 1'b0, 3'd7, 3'd7, 3'd0};

    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].rst,
            vecs[i].e1, vecs[i].e2, vecs[i].e3, $sformatf("vec%0d", i));
    end

    // Latency: outputs must hold the previous result until the next edge.
    apply(3'd0, 3'd7, 3'd0, 1'b0, 3'd7, 3'd0, 3'd0, "lat_first");
    a = 3'd7; b = 3'd0; c = 3'd7;
    #3;
    check("lat_hold", 3'd7, 3'd0, 3'd0);
    @(posedge clk);
    #1;
    check("lat_second", 3'd7, 3'd7, 3'd0);

    // Reset priority over live data, then immediate recovery.
    apply(3'd6, 3'd2, 3'd4, 1'b1, 3'd0, 3'd0, 3'd0, "rst_prio");
    apply(3'd2, 3'd6, 3'd4, 1'b0, 3'd6, 3'd4, 3'd2, "rst_recover");

    for (int i = 0; i < 512; i++) begin
      logic [8:0] exp_v;
      logic [2:0] ta, tb, tc;
      ta = i[8:6];
      tb = i[5:3];
      tc = i[2:0];
      exp_v = sort_model(int'(ta), int'(tb), int'(tc));
      if (i == 200) begin
        apply(ta, tb, tc, 1'b1, 3'd0, 3'd0, 3'd0, "sweep_rst");
      end
      apply(ta, tb, tc, 1'b0, exp_v[8:6], exp_v[5:3], exp_v[2:0],
            $sformatf("sweep_%0d_%0d_%0d", ta, tb, tc));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sort_1.md
# sort_1

Three-input sorter. Every clock it samples three unsigned operands `a`, `b` and `c`, orders them with a three-stage bubble-sort compare/exchange network, and registers the result on `no1`, `no2` and `no3`. It is a standalone, fully pipelined datapath leaf with no handshake, and it accepts a new operand triple every cycle.

## Interface
- `width`, default 3: bit width of each operand and each output.

- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `a`  input  `width`  operand 0, unsigned.
- `b`  input  `width`  operand 1, unsigned.
- `c`  input  `width`  operand 2, unsigned.
- `no1`  output  `width`  largest of the sampled `{a,b,c}`, registered.
- `no2`  output  `width`  middle (median) of the sampled triple, registered.
- `no3`  output  `width`  smallest of the sampled triple, registered.

## Operation
- Ordering rule: `no1 >= no2 >= no3`, descending, unsigned comparison over the full `width` bits.
- Network is combinational bubble sort on `(x0,x1,x2) = (a,b,c)`:
  - stage 1: compare/exchange `(x0,x1)`; larger goes to x0.
  - stage 2: compare/exchange `(x1,x2)`; larger goes to x1.
  - stage 3: compare/exchange `(x0,x1)`; larger goes to x0.
  - Result `(x0,x1,x2)` feeds the `no1`/`no2`/`no3` registers.
- Exchange happens only on strict greater-than. Equal operands are left in place; ties produce identical values, so the output is unambiguous.
- Outputs are always a permutation of the sampled inputs. No value is created, dropped or truncated.
- No internal state exists other than the three output registers.
- Each sample is independent of all previous samples.

## Timing
- Latency is 1 cycle. Inputs sampled at rising edge N appear on `no1..no3` immediately after edge N and hold until edge N+1.
- Throughput is one triple per cycle. Outputs are valid every cycle after reset deassertion; there is no valid or ready signal.
- Reset: if `rst=1` at a rising edge, all three outputs become 0 at that edge, regardless of `a`, `b` and `c`.
- Reset mid-stream: the triple presented on a reset edge is discarded. The first edge with `rst=0` samples and sorts normally.
- Reset takes priority over data. No asynchronous behaviour.
- Outputs are X/undefined before the first reset edge; the bench must reset first.
- Combinational path `a/b/c -> registers` is three compare/mux stages deep. Inputs must be stable by setup time before the rising edge.

## Test plan
- Reset: hold `rst=1` for 2 edges with `a=7, b=5, c=3` -> `no1=no2=no3=0`. Deassert, then after 1 edge -> `7,5,3`.
- Permutations: apply all six orderings of `{1,4,6}`, one per cycle -> every cycle, one cycle later, reads `no1=6, no2=4, no3=1`.
- Ties: `(3,3,1)` -> `3,3,1`; `(2,5,5)` -> `5,5,2`; `(0,0,0)` -> `0,0,0`; `(7,7,7)` -> `7,7,7`.
- Extremes and latency: back-to-back `(0,7,0)` then `(7,0,7)` -> `7,0,0` then `7,7,0`, each exactly one cycle after its input edge.
- Exhaustive: sweep all 512 `(a,b,c)` with `width=3`, one per cycle, comparing against a descending-sort model delayed by one cycle -> 0 mismatches, 512 passes.
- Reset mid-stream: during the sweep assert `rst` for one edge -> outputs 0 for that cycle, then correct sorting resumes on the next sampled triple.
